// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int REG_W   = 5;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// Single-entry buffer holding the fetched instruction and its PC for decode.
module ifu_inst_buf
  import ifu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [XLEN-1:0]  load_inst,
  input  logic [XLEN-1:0]  load_pc,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic [REG_W-1:0] out_rd,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2
);

  logic            valid_r;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] pc_r;

  // Buffer entry: clear wins over load so a redirect always drops the entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      inst_r  <= '0;
      pc_r    <= '0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      inst_r  <= load_inst;
      pc_r    <= load_pc;
    end
  end

  assign out_valid = valid_r;
  assign out_inst  = inst_r;
  assign out_pc    = pc_r;
  assign out_rd    = inst_r[RD_LSB  +: REG_W];
  assign out_rs1   = inst_r[RS1_LSB +: REG_W];
  assign out_rs2   = inst_r[RS2_LSB +: REG_W];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch initiator: owns the PC, issues one request at a time,
// and hands returned words to decode, honouring redirects from execute.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2
);

  state_e          state_r;
  logic [XLEN-1:0] pc_r;
  logic            kill_r;
  logic            req_valid_r;
  logic [XLEN-1:0] req_addr_r;
  logic [XLEN-1:0] target_s;
  logic            buf_load_s;
  logic            buf_clear_s;

  assign target_s = word_align(redirect_pc);

  // Buffer control decoded from the current state and handshakes.
  always_comb begin
    buf_load_s  = 1'b0;
    buf_clear_s = 1'b0;
    if (state_r == WAIT) begin
      buf_load_s = mem_rsp_valid && !kill_r && !redirect_valid;
    end else if (state_r == HOLD) begin
      buf_clear_s = redirect_valid || out_ready;
    end else begin
      buf_load_s  = 1'b0;
      buf_clear_s = 1'b0;
    end
  end

  // Fetch FSM; req_addr_r is frozen while a request is pending so a redirect
  // only retargets pc and marks the in-flight fetch for dropping via kill_r.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= REQ;
      pc_r        <= RESET_PC;
      kill_r      <= 1'b0;
      req_valid_r <= 1'b0;
      req_addr_r  <= RESET_PC;
    end else begin
      case (state_r)
        REQ: begin
          if (!req_valid_r) begin
            req_valid_r <= 1'b1;
            if (redirect_valid) begin
              pc_r       <= target_s;
              req_addr_r <= target_s;
            end else begin
              req_addr_r <= pc_r;
            end
          end else begin
            if (mem_req_ready) begin
              req_valid_r <= 1'b0;
              state_r     <= WAIT;
            end
            if (redirect_valid) begin
              pc_r   <= target_s;
              kill_r <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_r <= target_s;
            if (mem_rsp_valid) begin
              kill_r      <= 1'b0;
              state_r     <= REQ;
              req_valid_r <= 1'b1;
              req_addr_r  <= target_s;
            end else begin
              kill_r <= 1'b1;
            end
          end else if (mem_rsp_valid) begin
            if (kill_r) begin
              kill_r      <= 1'b0;
              state_r     <= REQ;
              req_valid_r <= 1'b1;
              req_addr_r  <= pc_r;
            end else begin
              pc_r    <= pc_r + XLEN'(32'd4);
              state_r <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_r        <= target_s;
            state_r     <= REQ;
            req_valid_r <= 1'b1;
            req_addr_r  <= target_s;
          end else if (out_ready) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
            req_addr_r  <= pc_r;
          end
        end
        default: begin
          state_r     <= REQ;
          kill_r      <= 1'b0;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = req_addr_r;

  ifu_inst_buf #(.XLEN(XLEN)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load_s),
    .clear     (buf_clear_s),
    .load_inst (mem_rsp_data),
    .load_pc   (pc_r),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_rd    (out_rd),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2)
  );

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch initiator that drives the requesting side of the instruction-memory interface.
- Owns the PC and issues one fetch request at a time over a valid/ready request channel.
- Accepts the returned 32-bit instruction word and presents it, with its PC and raw register fields, to decode through a valid/ready output channel.
- Handles control-flow redirects from execute, including squashing any in-flight fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; bits [1:0] must be 0.
XLEN, 32, address and instruction width; only 32 is supported.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
mem_req_valid  output  1  fetch request valid.
mem_req_ready  input  1  memory accepts request this cycle.
mem_req_addr  output  32  fetch address, word aligned.
mem_rsp_valid  input  1  instruction word valid, at most one per accepted request, ≥1 cycle after acceptance.
mem_rsp_data  input  32  returned instruction word.
redirect_valid  input  1  control-flow redirect pulse.
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
out_valid  output  1  fetched instruction available to decode.
out_ready  input  1  decode accepts instruction.
out_inst  output  32  instruction word.
out_pc  output  32  PC of out_inst.
out_rd  output  5  out_inst[11:7].
out_rs1  output  5  out_inst[19:15].
out_rs2  output  5  out_inst[24:20].

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_PC, state=REQ, kill=0.
  - out_valid=0, out_inst=0, out_pc=0.
  - mem_req_valid=0 during reset cycles.
- States: REQ, WAIT, HOLD.
- REQ:
  - mem_req_valid=1, mem_req_addr=pc.
  - On mem_req_ready=1: go to WAIT.
  - The request is never retracted and the address never changes until accepted.
- WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid with kill=0: capture data into the output buffer, out_pc=pc, pc<=pc+4 (mod 2^32), go to HOLD.
  - On mem_rsp_valid with kill=1: discard data, kill<=0, go to REQ.
- HOLD:
  - out_valid=1; out_* stable while out_ready=0.
  - On out_ready: out_valid<=0, go to REQ.
  - Next request issues the cycle after the handshake.
- Latency:
  - out_valid rises the cycle after mem_rsp_valid.
  - Best-case throughput is one instruction per 3 cycles with a 1-cycle memory.
- Redirect (highest priority, one cycle pulse):
  - REQ, request not yet accepted: pc<=redirect_pc; kill<=1, because the old request must still complete (stable-address rule). With mem_req_ready=1 in the same cycle: request accepted, kill<=1, pc<=redirect_pc.
  - WAIT: pc<=redirect_pc, kill<=1. If mem_rsp_valid arrives in the same cycle, that response is dropped, kill stays 0, and the FSM goes to REQ.
  - HOLD: buffered instruction discarded, out_valid<=0, pc<=redirect_pc, go to REQ. A simultaneous out_ready is ignored (instruction not consumed).
- Redirect in REQ with kill already 1: pc overwritten; kill stays 1 (single outstanding request).
- Field outputs are pure slices of the registered out_inst; the block does no decoding.
- Reset mid-operation: all state cleared in the same edge; a later stray mem_rsp_valid in REQ is ignored.
- pc+4 from 32'hFFFF_FFFC wraps to 0.

Decomposition:
- Package ifu_pkg:
  - state enum {REQ, WAIT, HOLD}
  - RESET_PC default
  - field slice constants RD_LSB=7, RS1_LSB=15, RS2_LSB=20, REG_W=5
- Sub-module ifu_inst_buf: single-entry inst/pc register with load/clear/valid, owning out_valid and out_*.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle response 32'h00500093 -> addr 80000000, out_valid with out_pc=80000000, out_rd=1, out_rs1=0, out_rs2=5; next addr 80000004.
- out_ready=0 for 5 cycles in HOLD -> out_* constant, mem_req_valid=0; after out_ready, next request to pc+4.
- mem_req_ready low 3 cycles with redirect_pc=80000100 in cycle 2 -> mem_req_addr holds 80000000 until accepted; response dropped; next request 80000100.
- Redirect to 80000203 coincident with mem_rsp_valid in WAIT -> data dropped, next addr 80000200.
- Redirect and out_ready same cycle in HOLD -> out_valid falls, no duplicate, next addr = redirect target.
- pc=FFFFFFFC fetched -> next addr 00000000; assert rst_n=0 during WAIT -> out_valid=0, next addr RESET_PC.
